// File: rtl/rc4_encryptor.sv
// RC4 stream-cipher encryptor: S-box init, key schedule, then PRGA over MSG_LEN
// plaintext bytes, writing ct[k] = pt[k] ^ keystream[k] to the ciphertext RAM.
// The S RAM and the plaintext ROM both have one cycle of read latency.
module rc4_encryptor #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned AW      = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [23:0]   secret_key,
    output logic          busy,
    output logic          done,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_wdata,
    output logic          s_we,
    input  logic [7:0]    s_rdata,
    output logic [AW-1:0] pt_addr,
    input  logic [7:0]    pt_rdata,
    output logic [AW-1:0] ct_addr,
    output logic [7:0]    ct_wdata,
    output logic          ct_we
);

    typedef enum logic [2:0] {StIdle, StInit, StKsa, StPrga, StDone} state_t;

    state_t        state;
    logic [2:0]    phase;
    logic [7:0]    i;
    logic [7:0]    j;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [7:0]    pt;
    logic [AW-1:0] k;
    logic [1:0]    kidx;   // i mod 3, tracked incrementally during KSA
    logic [23:0]   key;

    logic [7:0] key_byte;
    logic [7:0] j_ksa;
    logic [7:0] j_prga;
    logic [7:0] i_inc;
    logic       last_k;

    assign key_byte = (kidx == 2'd0) ? key[23:16] : (kidx == 2'd1) ? key[15:8] : key[7:0];
    assign j_ksa    = j + s_rdata + key_byte;
    assign j_prga   = j + s_rdata;
    assign i_inc    = i + 8'd1;
    assign last_k   = (k == AW'(MSG_LEN - 1));

    // Status flags decode directly from the state register.
    assign busy = (state == StInit) || (state == StKsa) || (state == StPrga);
    assign done = (state == StDone);

    // Memory-port drive per state/phase; the read-to-address paths in K1/P1 must be
    // combinational because the new j depends on the RAM data arriving that cycle.
    always_comb begin
        s_addr   = 8'd0;
        s_wdata  = 8'd0;
        s_we     = 1'b0;
        pt_addr  = '0;
        ct_addr  = '0;
        ct_wdata = 8'd0;
        ct_we    = 1'b0;
        case (state)
            StInit: begin
                s_addr  = i;
                s_wdata = i;
                s_we    = 1'b1;
            end
            StKsa: begin
                case (phase)
                    3'd0: s_addr = i;
                    3'd1: s_addr = j_ksa;
                    3'd2: begin
                        s_addr  = i;
                        s_wdata = s_rdata;
                        s_we    = 1'b1;
                    end
                    3'd3: begin
                        s_addr  = j;
                        s_wdata = si;
                        s_we    = 1'b1;
                    end
                    default: ;
                endcase
            end
            StPrga: begin
                case (phase)
                    3'd0: s_addr = i_inc;
                    3'd1: s_addr = j_prga;
                    3'd2: begin
                        s_addr  = i;
                        s_wdata = s_rdata;
                        s_we    = 1'b1;
                    end
                    3'd3: begin
                        s_addr  = j;
                        s_wdata = si;
                        s_we    = 1'b1;
                        pt_addr = k;
                    end
                    3'd4: s_addr = si + sj;
                    3'd5: begin
                        ct_addr  = k;
                        ct_wdata = s_rdata ^ pt;
                        ct_we    = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Main sequencer: state, phase counter, indices and latched operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            phase <= 3'd0;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            pt    <= 8'd0;
            k     <= '0;
            kidx  <= 2'd0;
            key   <= 24'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        key   <= secret_key;
                        i     <= 8'd0;
                        j     <= 8'd0;
                        k     <= '0;
                        phase <= 3'd0;
                        state <= StInit;
                    end
                end
                StInit: begin
                    i <= i_inc;  // wraps to 0 after 255, ready for KSA
                    if (i == 8'd255) begin
                        j     <= 8'd0;
                        kidx  <= 2'd0;
                        phase <= 3'd0;
                        state <= StKsa;
                    end
                end
                StKsa: begin
                    phase <= phase + 3'd1;
                    case (phase)
                        3'd1: begin
                            j  <= j_ksa;
                            si <= s_rdata;
                        end
                        3'd2: sj <= s_rdata;
                        3'd3: begin
                            phase <= 3'd0;
                            i     <= i_inc;
                            kidx  <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                            if (i == 8'd255) begin
                                j     <= 8'd0;
                                k     <= '0;
                                state <= StPrga;
                            end
                        end
                        default: ;
                    endcase
                end
                StPrga: begin
                    phase <= phase + 3'd1;
                    case (phase)
                        3'd0: i <= i_inc;
                        3'd1: begin
                            j  <= j_prga;
                            si <= s_rdata;
                        end
                        3'd2: sj <= s_rdata;
                        3'd4: pt <= pt_rdata;
                        3'd5: begin
                            phase <= 3'd0;
                            if (last_k) begin
                                state <= StDone;
                            end else begin
                                k <= k + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_encryptor.sv
// Self-checking bench for rc4_encryptor: memory models around the DUT, a plain
// RC4 reference model, randomized keys/plaintext, timing and strobe counts.
module tb_rc4_encryptor;
    localparam int unsigned MSG_LEN = 32;
    localparam int unsigned AW      = 5;
    localparam int DONE_AT = 1 + 256 + 1024 + 6 * MSG_LEN;

    logic          clk;
    logic          reset;
    logic          start;
    logic [23:0]   secret_key;
    logic          busy;
    logic          done;
    logic [7:0]    s_addr;
    logic [7:0]    s_wdata;
    logic          s_we;
    logic [7:0]    s_rdata;
    logic [AW-1:0] pt_addr;
    logic [7:0]    pt_rdata;
    logic [AW-1:0] ct_addr;
    logic [7:0]    ct_wdata;
    logic          ct_we;

    rc4_encryptor #(.MSG_LEN(MSG_LEN), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .busy       (busy),
        .done       (done),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_we       (s_we),
        .s_rdata    (s_rdata),
        .pt_addr    (pt_addr),
        .pt_rdata   (pt_rdata),
        .ct_addr    (ct_addr),
        .ct_wdata   (ct_wdata),
        .ct_we      (ct_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memories surrounding the DUT.
    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [2**AW];
    logic [7:0] ct_mem [2**AW];

    always @(posedge clk) begin
        if (s_we) s_mem[s_addr] <= s_wdata;
        s_rdata  <= s_mem[s_addr];
        pt_rdata <= pt_mem[pt_addr];
        if (ct_we) ct_mem[ct_addr] <= ct_wdata;
    end

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference keystream from the textbook RC4 algorithm.
    int ks [MSG_LEN];

    task automatic ref_model(input logic [23:0] key);
        int s [256];
        int kb [3];
        int a;
        int b;
        int t;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int n = 0; n < 256; n++) s[n] = n;
        b = 0;
        for (int n = 0; n < 256; n++) begin
            b = (b + s[n] + kb[n % 3]) % 256;
            t = s[n]; s[n] = s[b]; s[b] = t;
        end
        a = 0;
        b = 0;
        for (int m = 0; m < MSG_LEN; m++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            t = s[a]; s[a] = s[b]; s[b] = t;
            ks[m] = s[(s[a] + s[b]) % 256];
        end
    endtask

    // Per-run observations.
    int done_cycle;
    int busy_cnt;
    int swe_init;
    int ctwe_cnt;
    int done_cnt;
    int init_bad;

    task automatic run(input logic [23:0] key, input bit noisy, input int abort_at,
                       output bit aborted);
        aborted = 1'b0;
        for (int m = 0; m < 2**AW; m++) ct_mem[m] = 8'($urandom);
        done_cycle = -1;
        busy_cnt   = 0;
        swe_init   = 0;
        ctwe_cnt   = 0;
        done_cnt   = 0;
        init_bad   = -1;
        @(negedge clk);
        secret_key = key;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= DONE_AT + 8; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (s_we && c <= 256) swe_init++;
            if (ct_we) ctwe_cnt++;
            if (c == 257) begin
                init_bad = 0;
                for (int m = 0; m < 256; m++) if (s_mem[m] !== 8'(m)) init_bad++;
            end
            if (c == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(posedge clk);
                #1;
                check("abort_busy", busy, 0);
                check("abort_ct_we", ct_we, 0);
                check("abort_s_we", s_we, 0);
                check("abort_done", done, 0);
                reset   = 1'b0;
                aborted = 1'b1;
                return;
            end
            start = (noisy && done_cycle < 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input logic [23:0] key);
        check("done_cycle", done_cycle, DONE_AT);
        check("busy_cycles", busy_cnt, DONE_AT - 1);
        check("init_s_we", swe_init, 256);
        check("init_s_identity_bad", init_bad, 0);
        check("ct_we_count", ctwe_cnt, MSG_LEN);
        check("done_count", done_cnt, 1);
        check("idle_after", busy, 0);
        ref_model(key);
        for (int m = 0; m < MSG_LEN; m++) begin
            check($sformatf("ct[%0d] key=%06h", m, key), ct_mem[m], 8'(ks[m]) ^ pt_mem[m]);
        end
    endtask

    logic [71:0] pt_txt;
    logic [71:0] exp_ct;
    logic [7:0]  pt_orig [MSG_LEN];
    logic [7:0]  ct_save [MSG_LEN];
    bit          ab;

    task automatic load_vector();
        for (int m = 0; m < MSG_LEN; m++) begin
            pt_mem[m] = (m < 9) ? pt_txt[71 - 8 * m -: 8] : 8'($urandom);
            pt_orig[m] = pt_mem[m];
        end
    endtask

    task automatic check_vector(input string tag);
        for (int m = 0; m < 9; m++) begin
            check($sformatf("%s[%0d]", tag, m), ct_mem[m], exp_ct[71 - 8 * m -: 8]);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        pt_txt     = "Plaintext";
        exp_ct     = 72'hBBF316E8D940AF0AD3;
        reset      = 1'b1;
        start      = 1'b1;
        secret_key = 24'hFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s_we", s_we, 0);
        check("rst_ct_we", ct_we, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_pt_addr", pt_addr, 0);
        check("rst_ct_addr", ct_addr, 0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        // Known-answer vector, with noisy start while busy.
        load_vector();
        run(24'h4B6579, 1'b1, 0, ab);
        check_run(24'h4B6579);
        check_vector("kat");
        for (int m = 0; m < MSG_LEN; m++) ct_save[m] = ct_mem[m];

        // Round trip: ciphertext fed back must reproduce the plaintext.
        for (int m = 0; m < MSG_LEN; m++) pt_mem[m] = ct_save[m];
        run(24'h4B6579, 1'b0, 0, ab);
        check_run(24'h4B6579);
        for (int m = 0; m < MSG_LEN; m++) check($sformatf("roundtrip[%0d]", m), ct_mem[m], pt_orig[m]);

        // All-zero key, random plaintext.
        for (int m = 0; m < MSG_LEN; m++) pt_mem[m] = 8'($urandom);
        run(24'h000000, 1'b1, 0, ab);
        check_run(24'h000000);

        // Reset during PRGA byte 4 (phase P2), then a clean known-answer run.
        run(24'($urandom), 1'b0, 1281 + 6 * 4 + 2, ab);
        check("abort_taken", ab, 1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", busy, 0);
        load_vector();
        run(24'h4B6579, 1'b0, 0, ab);
        check_run(24'h4B6579);
        check_vector("kat_after_abort");

        // Random keys and plaintext.
        for (int r = 0; r < 3; r++) begin
            logic [23:0] key;
            key = 24'($urandom);
            for (int m = 0; m < MSG_LEN; m++) pt_mem[m] = 8'($urandom);
            run(key, 1'($urandom_range(0, 1)), 0, ab);
            check_run(key);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
